// File: rtl/sync_fifo.sv
// Single-clock FIFO of DEPTH words of WIDTH bits.
// Pointers carry one extra wrap bit so that full and empty can be told apart
// without a separate occupancy counter. Read data is registered with one
// cycle of latency. Rejected accesses raise one-cycle over_flow/under_flow pulses.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             over_flow,
    output logic             under_flow
);

    localparam logic [PTR_WIDTH:0] C_PTR_ZERO = {(PTR_WIDTH + 1){1'b0}};
    localparam logic [PTR_WIDTH:0] C_PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};

    // Storage array; deliberately not cleared by reset.
    logic [WIDTH-1:0]     r_mem [0:DEPTH-1];

    logic [PTR_WIDTH:0]   r_wr_ptr;
    logic [PTR_WIDTH:0]   r_rd_ptr;
    logic [WIDTH-1:0]     r_rdata;
    logic                 r_over_flow;
    logic                 r_under_flow;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_wr_accept;
    logic                 w_rd_accept;
    logic [PTR_WIDTH-1:0] w_wr_addr;
    logic [PTR_WIDTH-1:0] w_rd_addr;

    // Status flags and access acceptance, all decoded from the registered pointers.
    always_comb begin
        w_wr_addr   = r_wr_ptr[PTR_WIDTH-1:0];
        w_rd_addr   = r_rd_ptr[PTR_WIDTH-1:0];
        w_empty     = (r_wr_ptr == r_rd_ptr);
        w_full      = (w_wr_addr == w_rd_addr) &&
                      (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]);
        w_wr_accept = 1'b0;
        w_rd_accept = 1'b0;
        if (wr_en && !w_full) begin
            w_wr_accept = 1'b1;
        end else begin
            w_wr_accept = 1'b0;
        end
        if (rd_en && !w_empty) begin
            w_rd_accept = 1'b1;
        end else begin
            w_rd_accept = 1'b0;
        end
    end

    // Array write port: stores wdata at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (res && w_wr_accept) begin
            r_mem[w_wr_addr] <= wdata;
        end
    end

    // Write pointer: advances modulo 2**(PTR_WIDTH+1) on each accepted write.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_wr_ptr <= C_PTR_ZERO;
        end else if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
    end

    // Read pointer and registered read data: rdata holds unless a read is accepted.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_rd_ptr <= C_PTR_ZERO;
            r_rdata  <= {WIDTH{1'b0}};
        end else if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            r_rdata  <= r_mem[w_rd_addr];
        end
    end

    // Error pulses: record a rejected write or read seen at this edge.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_over_flow  <= 1'b0;
            r_under_flow <= 1'b0;
        end else begin
            r_over_flow  <= wr_en & w_full;
            r_under_flow <= rd_en & w_empty;
        end
    end

    assign rdata      = r_rdata;
    assign empty      = w_empty;
    assign full       = w_full;
    assign over_flow  = r_over_flow;
    assign under_flow = r_under_flow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a table of short vectors from reset, then
// hand-written multi-cycle sequences checked against a queue reference model.
module tb_sync_fifo;

    logic       clk;
    logic       res;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
    logic       over_flow;
    logic       under_flow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rdata;
    logic       m_ov;
    logic       m_un;

    typedef struct {
        bit         r;
        bit         w;
        bit         rd;
        logic [7:0] wd;
        logic [7:0] e_rdata;
        bit         e_empty;
        bit         e_full;
        bit         e_ov;
        bit         e_un;
    } vec_t;

    vec_t vecs[12];

    sync_fifo #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4)) dut (
        .clk        (clk),
        .res        (res),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wdata      (wdata),
        .rdata      (rdata),
        .empty      (empty),
        .full       (full),
        .over_flow  (over_flow),
        .under_flow (under_flow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge with the given inputs; the model predicts and all outputs are compared.
    task automatic cyc(input bit r, input bit w, input bit rd, input logic [7:0] wd);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        res   = r;
        wr_en = w;
        rd_en = rd;
        wdata = wd;
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            m_rdata = 8'h00;
            m_ov    = 1'b0;
            m_un    = 1'b0;
        end else begin
            m_ov = w && was_full;
            m_un = rd && was_empty;
            if (rd && !was_empty) m_rdata = q.pop_front();
            if (w && !was_full) q.push_back(wd);
        end
        chk("m_rdata", rdata, m_rdata);
        chk("m_empty", empty, (q.size() == 0));
        chk("m_full", full, (q.size() == 16));
        chk("m_over_flow", over_flow, m_ov);
        chk("m_under_flow", under_flow, m_un);
    endtask

    initial begin
        res   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;
        m_rdata = 8'h00;
        m_ov = 1'b0;
        m_un = 1'b0;

        //            r     w     rd    wd     rdata  emp   full  ov    un
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h33, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h44, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            res   = vecs[i].r;
            wr_en = vecs[i].w;
            rd_en = vecs[i].rd;
            wdata = vecs[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
            chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("vec%0d_over_flow", i), over_flow, vecs[i].e_ov);
            chk($sformatf("vec%0d_under_flow", i), under_flow, vecs[i].e_un);
        end

        // Reset with both requests active
        cyc(1'b0, 1'b1, 1'b1, 8'h99);
        cyc(1'b0, 1'b1, 1'b1, 8'h99);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_empty", empty, 1'b1);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(i));
            chk("fill_empty", empty, 1'b0);
        end
        chk("fill_full", full, 1'b1);

        // Overflow while full
        cyc(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("ovf_pulse", over_flow, 1'b1);
        chk("ovf_full", full, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ovf_clear", over_flow, 1'b0);

        // Drain in order, no 0xAA
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'h00);
            chk("drain_data", rdata, 8'(i));
        end
        chk("drain_empty", empty, 1'b1);

        // Underflow for two edges
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'h00);
            chk("udf_pulse", under_flow, 1'b1);
            chk("udf_rdata", rdata, 8'h0F);
            chk("udf_empty", empty, 1'b1);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("udf_clear", under_flow, 1'b0);

        // Simultaneous access with 5 entries held
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'h50 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 8'h60 + 8'(i));
            chk("simul_data", rdata, (i < 5) ? (8'h50 + 8'(i)) : (8'h60 + 8'(i - 5)));
            chk("simul_occ", 32'(q.size()), 32'd5);
        end

        // Both requests while full: read wins, write rejected
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b1, 1'b0, 8'h70 + 8'(i));
        chk("full_before_both", full, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 8'hBB);
        chk("both_full_rdata", rdata, 8'h65);
        chk("both_full_ovf", over_flow, 1'b1);
        chk("both_full_notfull", full, 1'b0);
        while (q.size() != 0) cyc(1'b1, 1'b0, 1'b1, 8'h00);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, (i % 3) != 0, 8'h80 + 8'(i));
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("wrap_drained", empty, 1'b1);

        // Mid-operation reset with 7 entries held
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 8'hC0 + 8'(i));
        chk("pre_reset_empty", empty, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("midreset_empty", empty, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("midreset_udf", under_flow, 1'b1);
        chk("midreset_rdata", rdata, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
